// File: rtl/xorexpand_stream_if.sv
// Seed-in / chunk-out handshake bundle for the streaming XOR-expand PRG.
// The slave modport is the generator's view, the master modport is the
// view of the block that feeds seeds and consumes chunks.
interface xorexpand_stream_if #(
   parameter int RNDSIZE = 16,
   parameter int OUT_W   = 8
);
   localparam int N      = RNDSIZE * (RNDSIZE - 1) / 2;
   localparam int NCHUNK = (N + OUT_W - 1) / OUT_W;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   logic               in_valid;
   logic               in_ready;
   logic [RNDSIZE-1:0] in_seed;
   logic               rekey;
   logic               abort;
   logic               out_valid;
   logic               out_ready;
   logic [OUT_W-1:0]   out_data;
   logic               out_last;
   logic [CW-1:0]      out_idx;
   logic               busy;

   modport slave (
      input  in_valid, in_seed, rekey, abort, out_ready,
      output in_ready, out_valid, out_data, out_last, out_idx, busy
   );

   modport master (
      output in_valid, in_seed, rekey, abort, out_ready,
      input  in_ready, out_valid, out_data, out_last, out_idx, busy
   );
endinterface

// File: rtl/xorexpand_stream.sv
// Streaming XOR-expand PRG: takes an RNDSIZE-bit seed r and emits every
// pairwise XOR r[i]^r[j] (i<j) as OUT_W-bit chunks with backpressure.
// Pair (i,j) lands on expansion bit k = i*RNDSIZE - i*(i+1)/2 + j - i - 1.
// Optional rekey on the last chunk reseeds from the low RNDSIZE bits of the
// current expansion and continues without a bubble.
module xorexpand_stream #(
   parameter int RNDSIZE = 16,
   parameter int OUT_W   = 8
) (
   input logic                  clk,
   input logic                  rst,
   xorexpand_stream_if.slave    bus
);
   localparam int N      = RNDSIZE * (RNDSIZE - 1) / 2;
   localparam int NCHUNK = (N + OUT_W - 1) / OUT_W;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int PADW   = NCHUNK * OUT_W;

   typedef enum logic [0:0] {IDLE = 1'b0, STREAM = 1'b1} state_t;

   // Full pairwise-XOR expansion of a seed, in k order.
   function automatic logic [N-1:0] expand_seed(input logic [RNDSIZE-1:0] r);
      logic [N-1:0] e;
      int           k;
      e = '0;
      k = 0;
      for (int i = 0; i < RNDSIZE - 1; i++) begin
         for (int j = i + 1; j < RNDSIZE; j++) begin
            e[k] = r[i] ^ r[j];
            k    = k + 1;
         end
      end
      return e;
   endfunction

   // Seed for the next expansion when rekeying: low RNDSIZE expansion bits.
   function automatic logic [RNDSIZE-1:0] rekey_of(input logic [RNDSIZE-1:0] r);
      logic [N-1:0] e;
      e = expand_seed(r);
      return e[RNDSIZE-1:0];
   endfunction

   // Chunk c of the expansion; bits past N in the final chunk read as 0.
   function automatic logic [OUT_W-1:0] chunk_of(input logic [RNDSIZE-1:0] r,
                                                 input logic [CW-1:0]      c);
      logic [PADW-1:0]  pad;
      logic [OUT_W-1:0] d;
      pad        = '0;
      pad[N-1:0] = expand_seed(r);
      for (int b = 0; b < OUT_W; b++) begin
         d[b] = pad[int'(c) * OUT_W + b];
      end
      return d;
   endfunction

   state_t             state_r,  state_nx;
   logic [RNDSIZE-1:0] seed_r,   seed_nx;
   logic [CW-1:0]      cnt_r,    cnt_nx;
   logic               out_valid_r;
   logic [OUT_W-1:0]   out_data_r;
   logic               out_last_r;
   logic [CW-1:0]      out_idx_r;
   logic               busy_r;

   logic               in_ready_s;
   logic               in_hs_s;
   logic               out_hs_s;
   logic               last_s;
   logic [RNDSIZE-1:0] rekey_seed_s;

   // Handshake qualifiers; in_ready must drop in the same cycle as rst/abort.
   always_comb begin
      in_ready_s   = (state_r == IDLE) && !rst && !bus.abort;
      in_hs_s      = bus.in_valid && in_ready_s;
      out_hs_s     = out_valid_r && bus.out_ready;
      last_s       = (cnt_r == CW'(NCHUNK - 1));
      rekey_seed_s = rekey_of(seed_r);
   end

   // Next-state logic for the IDLE/STREAM controller, seed and chunk counter.
   always_comb begin
      state_nx = state_r;
      seed_nx  = seed_r;
      cnt_nx   = cnt_r;
      if (bus.abort) begin
         state_nx = IDLE;
         cnt_nx   = '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_hs_s) begin
                  seed_nx  = bus.in_seed;
                  cnt_nx   = '0;
                  state_nx = STREAM;
               end else begin
                  state_nx = IDLE;
               end
            end
            STREAM: begin
               if (out_hs_s) begin
                  if (last_s) begin
                     cnt_nx = '0;
                     if (bus.rekey) begin
                        seed_nx  = rekey_seed_s;
                        state_nx = STREAM;
                     end else begin
                        state_nx = IDLE;
                     end
                  end else begin
                     cnt_nx = cnt_r + CW'(1);
                  end
               end else begin
                  state_nx = STREAM;
               end
            end
            default: begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end
         endcase
      end
   end

   // State registers plus outputs registered from the next-state values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         seed_r      <= '0;
         cnt_r       <= '0;
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         out_last_r  <= 1'b0;
         out_idx_r   <= '0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nx;
         seed_r      <= seed_nx;
         cnt_r       <= cnt_nx;
         out_valid_r <= (state_nx == STREAM);
         out_data_r  <= (state_nx == STREAM) ? chunk_of(seed_nx, cnt_nx) : '0;
         out_last_r  <= (state_nx == STREAM) && (cnt_nx == CW'(NCHUNK - 1));
         out_idx_r   <= (state_nx == STREAM) ? cnt_nx : '0;
         busy_r      <= (state_nx != IDLE);
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_r;
   assign bus.out_data  = out_data_r;
   assign bus.out_last  = out_last_r;
   assign bus.out_idx   = out_idx_r;
   assign bus.busy      = busy_r;
endmodule

// File: tb/tb_xorexpand_stream.sv
// Directed bench for xorexpand_stream: a 4/4 instance for the small
// hand-worked vectors and a 16/8 instance for the default configuration.
module tb_xorexpand_stream;
   logic clk;
   logic rst;
   int   errors;
   int   checks;

   xorexpand_stream_if #(.RNDSIZE(4),  .OUT_W(4)) bus4 ();
   xorexpand_stream_if #(.RNDSIZE(16), .OUT_W(8)) bus16 ();

   xorexpand_stream #(.RNDSIZE(4), .OUT_W(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   xorexpand_stream #(.RNDSIZE(16), .OUT_W(8)) dut16 (
      .clk (clk),
      .rst (rst),
      .bus (bus16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Independent reference: chunk c of the 16-bit seed expansion, found by
   // searching for the (i,j) pair whose formula index equals each bit k.
   function automatic logic [7:0] model_chunk(input logic [15:0] r, input int c);
      logic [7:0] v;
      v = '0;
      for (int b = 0; b < 8; b++) begin
         for (int i = 0; i < 15; i++) begin
            for (int j = i + 1; j < 16; j++) begin
               if (i * 16 - i * (i + 1) / 2 + j - i - 1 == c * 8 + b) begin
                  v[b] = r[i] ^ r[j];
               end
            end
         end
      end
      return v;
   endfunction

   initial begin
      int  exp_c;
      int  stall;
      int  cyc;
      bit  done;
      logic [7:0] e16;

      errors = 0;
      checks = 0;
      rst = 1'b1;
      bus4.in_valid = 1'b0;  bus4.in_seed = '0;  bus4.rekey = 1'b0;
      bus4.abort = 1'b0;     bus4.out_ready = 1'b1;
      bus16.in_valid = 1'b0; bus16.in_seed = '0; bus16.rekey = 1'b0;
      bus16.abort = 1'b0;    bus16.out_ready = 1'b1;

      // ---- reset ----
      repeat (2) @(negedge clk);
      chk("rst_inready4",  32'(bus4.in_ready),  32'h0);
      chk("rst_inready16", 32'(bus16.in_ready), 32'h0);
      rst = 1'b0;
      #1;
      chk("rst_valid",   32'(bus16.out_valid), 32'h0);
      chk("rst_busy",    32'(bus16.busy),      32'h0);
      chk("rst_data",    32'(bus16.out_data),  32'h0);
      chk("rst_last",    32'(bus16.out_last),  32'h0);
      chk("rst_idx",     32'(bus16.out_idx),   32'h0);
      chk("rst_inready", 32'(bus16.in_ready),  32'h1);
      chk("rst_valid4",  32'(bus4.out_valid),  32'h0);

      // ---- 4/4, seed 0001, no rekey ----
      bus4.in_valid = 1'b1; bus4.in_seed = 4'b0001;
      @(negedge clk);
      bus4.in_valid = 1'b0;
      chk("s4_v0",   32'(bus4.out_valid), 32'h1);
      chk("s4_d0",   32'(bus4.out_data),  32'h7);
      chk("s4_i0",   32'(bus4.out_idx),   32'h0);
      chk("s4_l0",   32'(bus4.out_last),  32'h0);
      chk("s4_rdy0", 32'(bus4.in_ready),  32'h0);
      @(negedge clk);
      chk("s4_d1",   32'(bus4.out_data),  32'h0);
      chk("s4_i1",   32'(bus4.out_idx),   32'h1);
      chk("s4_l1",   32'(bus4.out_last),  32'h1);
      @(negedge clk);
      chk("s4_idle_v",   32'(bus4.out_valid), 32'h0);
      chk("s4_idle_b",   32'(bus4.busy),      32'h0);
      chk("s4_idle_rdy", 32'(bus4.in_ready),  32'h1);

      // ---- 4/4, seed 0001 with rekey on last chunk ----
      bus4.in_valid = 1'b1; bus4.in_seed = 4'b0001;
      @(negedge clk);
      bus4.in_valid = 1'b0;
      chk("rk_d0", 32'(bus4.out_data), 32'h7);
      @(negedge clk);
      chk("rk_d1", 32'(bus4.out_data), 32'h0);
      chk("rk_l1", 32'(bus4.out_last), 32'h1);
      bus4.rekey = 1'b1;
      @(negedge clk);
      bus4.rekey = 1'b0;
      chk("rk_n_v", 32'(bus4.out_valid), 32'h1);
      chk("rk_n_d0", 32'(bus4.out_data), 32'h4);
      chk("rk_n_i0", 32'(bus4.out_idx),  32'h0);
      chk("rk_n_l0", 32'(bus4.out_last), 32'h0);
      @(negedge clk);
      chk("rk_n_d1", 32'(bus4.out_data), 32'h3);
      chk("rk_n_i1", 32'(bus4.out_idx),  32'h1);
      chk("rk_n_l1", 32'(bus4.out_last), 32'h1);
      @(negedge clk);
      chk("rk_idle", 32'(bus4.out_valid), 32'h0);

      // ---- 16/8, seed 0001 ----
      bus16.in_valid = 1'b1; bus16.in_seed = 16'h0001;
      @(negedge clk);
      bus16.in_valid = 1'b0;
      for (int c = 0; c < 15; c++) begin
         e16 = (c == 0) ? 8'hFF : ((c == 1) ? 8'h7F : 8'h00);
         chk("d16_v",    32'(bus16.out_valid), 32'h1);
         chk("d16_data", 32'(bus16.out_data),  32'(e16));
         chk("d16_idx",  32'(bus16.out_idx),   32'(c));
         chk("d16_last", 32'(bus16.out_last),  (c == 14) ? 32'h1 : 32'h0);
         @(negedge clk);
      end
      chk("d16_idle",    32'(bus16.out_valid), 32'h0);
      chk("d16_idlerdy", 32'(bus16.in_ready),  32'h1);

      // ---- 16/8, seed FFFF: all-zero expansion ----
      bus16.in_valid = 1'b1; bus16.in_seed = 16'hFFFF;
      @(negedge clk);
      bus16.in_valid = 1'b0;
      for (int c = 0; c < 15; c++) begin
         chk("ff_data", 32'(bus16.out_data), 32'h0);
         chk("ff_idx",  32'(bus16.out_idx),  32'(c));
         @(negedge clk);
      end
      chk("ff_idle", 32'(bus16.out_valid), 32'h0);

      // ---- backpressure: 5-cycle stall at idx 3, then random ready ----
      bus16.in_valid = 1'b1; bus16.in_seed = 16'hB38D;
      @(negedge clk);
      bus16.in_valid = 1'b0;
      exp_c = 0; stall = 0; cyc = 0; done = 1'b0;
      while (!done && cyc < 400) begin
         chk("bp_valid", 32'(bus16.out_valid), 32'h1);
         chk("bp_idx",   32'(bus16.out_idx),   32'(exp_c));
         chk("bp_data",  32'(bus16.out_data),  32'(model_chunk(16'hB38D, exp_c)));
         chk("bp_last",  32'(bus16.out_last),  (exp_c == 14) ? 32'h1 : 32'h0);
         if (exp_c == 3 && stall < 5) begin
            bus16.out_ready = 1'b0;
            stall++;
         end else begin
            bus16.out_ready = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         cyc++;
         if (bus16.out_ready) begin
            if (exp_c == 14) done = 1'b1;
            else exp_c++;
         end
      end
      chk("bp_complete", 32'(done),  32'h1);
      chk("bp_stalled",  32'(stall), 32'd5);
      bus16.out_ready = 1'b1;
      chk("bp_idle", 32'(bus16.out_valid), 32'h0);

      // ---- abort at idx 6 with a concurrent seed ----
      bus16.in_valid = 1'b1; bus16.in_seed = 16'h0001;
      @(negedge clk);
      bus16.in_valid = 1'b0;
      repeat (6) @(negedge clk);
      chk("ab_idx6", 32'(bus16.out_idx), 32'h6);
      bus16.abort = 1'b1; bus16.in_valid = 1'b1; bus16.in_seed = 16'h0003;
      #1;
      chk("ab_rdy_in_abort", 32'(bus16.in_ready), 32'h0);
      @(negedge clk);
      bus16.abort = 1'b0;
      #1;
      chk("ab_valid", 32'(bus16.out_valid), 32'h0);
      chk("ab_busy",  32'(bus16.busy),      32'h0);
      chk("ab_idx",   32'(bus16.out_idx),   32'h0);
      chk("ab_rdy",   32'(bus16.in_ready),  32'h1);
      @(negedge clk);
      bus16.in_valid = 1'b0;
      chk("ab_new_v",  32'(bus16.out_valid), 32'h1);
      chk("ab_new_i",  32'(bus16.out_idx),   32'h0);
      chk("ab_new_d0", 32'(bus16.out_data),  32'hFE);
      @(negedge clk);
      chk("ab_new_d1", 32'(bus16.out_data),  32'hFF);
      @(negedge clk);

      // ---- reset mid-stream (idx 2) ----
      chk("rs_idx2", 32'(bus16.out_idx), 32'h2);
      rst = 1'b1;
      #1;
      chk("rs_rdy_in_rst", 32'(bus16.in_ready), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rs_valid", 32'(bus16.out_valid), 32'h0);
      chk("rs_busy",  32'(bus16.busy),      32'h0);
      chk("rs_data",  32'(bus16.out_data),  32'h0);
      chk("rs_last",  32'(bus16.out_last),  32'h0);
      chk("rs_idx",   32'(bus16.out_idx),   32'h0);
      chk("rs_rdy",   32'(bus16.in_ready),  32'h1);
      bus16.in_valid = 1'b1; bus16.in_seed = 16'h0001;
      @(negedge clk);
      bus16.in_valid = 1'b0;
      chk("rs_new_d0", 32'(bus16.out_data), 32'hFF);
      chk("rs_new_i0", 32'(bus16.out_idx),  32'h0);
      @(negedge clk);
      chk("rs_new_d1", 32'(bus16.out_data), 32'h7F);
      chk("rs_new_i1", 32'(bus16.out_idx),  32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
